// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared state type and SPselect encodings for the shift chain controller.
//   state_t   : IDLE / SHIFT / DONE frame sequencing states
//   SPSEL_PAR : SPselect level that makes every dcell load its parallel D input
//   SPSEL_SER : SPselect level that makes every dcell take its serial S input
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic SPSEL_PAR = 1'b1;
    localparam logic SPSEL_SER = 1'b0;

endpackage

// File: rtl/shift_ctrl_bit_counter.sv
// bit_counter: up-counter with synchronous clear and enable, flagging terminal count WIDTH-1.
//   clk   : system clock
//   rst   : synchronous active-high reset, forces the count to 0
//   i_clr : clear to 0 (takes priority over i_en)
//   i_en  : advance the count by one
//   o_cnt : current count
//   o_tc  : high while o_cnt == WIDTH-1
module bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) r_cnt <= '0;
        else if (i_en)    r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_ctrl.sv
// shift_ctrl: sequences parallel load then WIDTH serial shifts of a dcell chain, with start/busy/done handshake.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   start     : request one frame (sampled in IDLE only)
//   abort     : cancel the frame in progress (sampled in SHIFT)
//   fill      : value shifted into the head of the chain during SHIFT
//   SPselect  : shared chain select, 1 = parallel D, 0 = serial S
//   ser_in    : serial input of the first dcell
//   busy      : frame in progress
//   bit_valid : last cell's Sout holds a frame bit
//   bit_idx   : index of the bit on the last cell's Sout
//   done      : one-cycle pulse after a frame completes without abort
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             fill,
    output logic             SPselect,
    output logic             ser_in,
    output logic             busy,
    output logic             bit_valid,
    output logic [CNT_W-1:0] bit_idx,
    output logic             done
);

    state_t           r_state;
    logic             r_sp;
    logic             r_ser;
    logic             r_busy;
    logic             r_valid;
    logic             r_done;
    logic [CNT_W-1:0] w_cnt;
    logic             w_tc;
    logic             w_clr;

    // The counter only survives an edge that keeps us in SHIFT, so it reads 0
    // in the first SHIFT cycle and everywhere outside SHIFT.
    assign w_clr = (r_state != SHIFT) || abort || w_tc;

    bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_en  (r_state == SHIFT),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sp    <= SPSEL_PAR;
            r_ser   <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= SHIFT;
                    r_sp    <= SPSEL_SER;
                    r_ser   <= fill;
                    r_busy  <= 1'b1;
                    r_valid <= 1'b1;
                end
                SHIFT: if (abort || w_tc) begin
                    // abort beats the last bit: no done pulse
                    r_state <= abort ? IDLE : DONE;
                    r_sp    <= SPSEL_PAR;
                    r_ser   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= !abort;
                end else begin
                    r_ser   <= fill;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_sp    <= SPSEL_PAR;
                    r_ser   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign SPselect  = r_sp;
    assign ser_in    = r_ser;
    assign busy      = r_busy;
    assign bit_valid = r_valid;
    assign bit_idx   = w_cnt;
    assign done      = r_done;

endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: self-checking bench for shift_ctrl driving a behavioural dcell chain.
module tb_shift_ctrl;
    import shift_ctrl_pkg::*;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    typedef struct packed {
        logic          sp;
        logic          ser;
        logic          busy;
        logic          valid;
        logic [CW-1:0] idx;
        logic          done;
    } exp_t;

    typedef struct {
        logic rst;
        logic start;
        logic abort;
        logic fill;
        exp_t e;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, start, abort, fill;
    logic          SPselect, ser_in, busy, bit_valid, done;
    logic [CW-1:0] bit_idx;
    logic [W-1:0]  pdata;
    logic [W-1:0]  chain = '0;
    exp_t          q[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    // chain[0] is the first dcell (fed by ser_in), chain[W-1] drives the last Sout
    always @(posedge clk) chain <= (SPselect == SPSEL_PAR) ? pdata : {chain[W-2:0], ser_in};

    shift_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .fill      (fill),
        .SPselect  (SPselect),
        .ser_in    (ser_in),
        .busy      (busy),
        .bit_valid (bit_valid),
        .bit_idx   (bit_idx),
        .done      (done)
    );

    function automatic exp_t mk(logic sp, logic ser, logic bz, logic v, int idx, logic d);
        exp_t e;
        e.sp = sp; e.ser = ser; e.busy = bz; e.valid = v; e.idx = CW'(idx); e.done = d;
        return e;
    endfunction

    task automatic check(input string name);
        exp_t x, got;
        x = q.pop_front();
        got.sp = SPselect; got.ser = ser_in; got.busy = busy;
        got.valid = bit_valid; got.idx = bit_idx; got.done = done;
        n_tests++;
        if (got !== x) begin
            n_fail++;
            $display("FAIL %s: got sp=%b ser=%b busy=%b valid=%b idx=%0d done=%b, want sp=%b ser=%b busy=%b valid=%b idx=%0d done=%b",
                     name, got.sp, got.ser, got.busy, got.valid, got.idx, got.done,
                     x.sp, x.ser, x.busy, x.valid, x.idx, x.done);
        end
        if (x.valid) begin
            n_tests++;
            if (chain[W-1] !== pdata[W-1-int'(x.idx)]) begin
                n_fail++;
                $display("FAIL %s sout: bit %0d got %b want %b", name, x.idx, chain[W-1], pdata[W-1-int'(x.idx)]);
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic a, input logic f, input exp_t e, input string name);
        rst = r; start = s; abort = a; fill = f;
        q.push_back(e);
        @(posedge clk);
        #1;
        check(name);
    endtask

    // One frame from IDLE; abort_at<0 means run to completion.
    // fmode: 0 fill=0, 1 fill=1, 2 random fill. hold keeps start high throughout.
    task automatic run_frame(input int abort_at, input logic hold, input int fmode, input string name);
        logic f;
        f = (fmode == 2) ? 1'($urandom_range(0, 1)) : 1'(fmode);
        step(0, 1, 0, f, mk(SPSEL_SER, f, 1, 1, 0, 0), {name, " start"});
        for (int k = 0; k < W; k++) begin
            f = (fmode == 2) ? 1'($urandom_range(0, 1)) : 1'(fmode);
            if (k == abort_at) begin
                step(0, hold, 1, f, mk(SPSEL_PAR, 0, 0, 0, 0, 0), {name, " abort"});
                return;
            end
            if (k == W - 1) step(0, hold, 0, f, mk(SPSEL_PAR, 0, 0, 0, 0, 1), {name, " done"});
            else            step(0, hold, 0, f, mk(SPSEL_SER, f, 1, 1, k + 1, 0), {name, " shift"});
        end
        if (fmode == 1) begin
            n_tests++;
            if (chain !== '1) begin
                n_fail++;
                $display("FAIL %s fill: chain got %h want %h", name, chain, {W{1'b1}});
            end
        end
        step(0, hold, 0, 0, mk(SPSEL_PAR, 0, 0, 0, 0, 0), {name, " after done"});
    endtask

    initial begin
        vec_t tv[10];
        rst = 1'b1; start = 1'b0; abort = 1'b0; fill = 1'b0; pdata = 8'hA5;
        #1;
        // reset, start, a few shifts, then reset for two cycles at bit_idx=3
        tv[0] = '{1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0)};
        tv[1] = '{1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0)};
        tv[2] = '{0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0)};
        tv[3] = '{0, 1, 0, 1, mk(0, 1, 1, 1, 0, 0)};
        tv[4] = '{0, 0, 0, 0, mk(0, 0, 1, 1, 1, 0)};
        tv[5] = '{0, 1, 0, 1, mk(0, 1, 1, 1, 2, 0)};
        tv[6] = '{0, 0, 0, 1, mk(0, 1, 1, 1, 3, 0)};
        tv[7] = '{1, 0, 1, 1, mk(1, 0, 0, 0, 0, 0)};
        tv[8] = '{1, 1, 0, 1, mk(1, 0, 0, 0, 0, 0)};
        tv[9] = '{0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0)};
        for (int i = 0; i < 10; i++)
            step(tv[i].rst, tv[i].start, tv[i].abort, tv[i].fill, tv[i].e, $sformatf("vec%0d", i));

        pdata = 8'hA5;
        run_frame(-1, 0, 0, "frame_a5");
        pdata = 8'h3C;
        run_frame(-1, 0, 1, "fill_ones");
        pdata = 8'h5A;
        run_frame(-1, 0, 2, "fill_rand");

        pdata = 8'hC3;
        run_frame(4, 0, 0, "abort4");
        step(0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0), "abort4 idle");
        run_frame(-1, 0, 0, "after_abort");

        pdata = 8'h96;
        run_frame(7, 0, 1, "abort7");
        step(0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0), "abort7 idle");

        pdata = 8'h81;
        for (int i = 0; i < 3; i++) run_frame(-1, 1, 2, $sformatf("hold%0d", i));
        step(0, 0, 0, 0, mk(1, 0, 0, 0, 0, 0), "final idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
